// File: rtl/pwm_head.sv
// PWM time base: up-counter wrapping at a shadowed period, shadowed compare
// register, zero/period/compare match decodes and a complementary PWM pair.
module pwm_head #(
  parameter int                WIDTH     = 12,
  parameter logic [WIDTH-1:0]  PRD_RESET = 12'hFFF
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             Clk_en,
  input  logic             Load_en,
  input  logic [WIDTH-1:0] Load,
  input  logic [WIDTH-1:0] reg_cc,
  output logic [WIDTH-1:0] op,
  output logic [WIDTH-1:0] counter_out,
  output logic             Ctr_0,
  output logic             comparator_out,
  output logic             comparator_out_cc,
  output logic             T1,
  output logic             T2
);

  logic [WIDTH-1:0] shadow_prd;
  logic [WIDTH-1:0] active_prd;
  logic [WIDTH-1:0] active_cc;
  logic [WIDTH-1:0] cnt;
  logic             boundary;

  assign boundary = (cnt == active_prd);

  // The shadow is written independently of Clk_en so software can stage a
  // new period while the time base is paused.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      shadow_prd <= PRD_RESET;
    end else if (Load_en) begin
      shadow_prd <= Load;
    end
  end

  // Period and compare only move at the wrap, so cnt can never exceed op.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      cnt        <= '0;
      active_prd <= PRD_RESET;
      active_cc  <= '0;
    end else if (Clk_en) begin
      if (boundary) begin
        cnt        <= '0;
        active_prd <= shadow_prd;
        active_cc  <= reg_cc;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign op                = active_prd;
  assign counter_out       = cnt;
  assign Ctr_0             = (cnt == '0);
  assign comparator_out    = boundary;
  assign comparator_out_cc = (cnt == active_cc);
  assign T1                = (cnt < active_cc);
  assign T2                = ~T1;

endmodule

// File: tb/tb_pwm_head.sv
// Directed bench for pwm_head: reset, period shadowing, duty decode, pause
// and mid-period reset, each scenario in its own task.
module tb_pwm_head;

  logic        Clock;
  logic        Rst;
  logic        Clk_en;
  logic        Load_en;
  logic [11:0] Load;
  logic [11:0] reg_cc;
  logic [11:0] op;
  logic [11:0] counter_out;
  logic        Ctr_0;
  logic        comparator_out;
  logic        comparator_out_cc;
  logic        T1;
  logic        T2;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_head dut (
    .Clock             (Clock),
    .Rst               (Rst),
    .Clk_en            (Clk_en),
    .Load_en           (Load_en),
    .Load              (Load),
    .reg_cc            (reg_cc),
    .op                (op),
    .counter_out       (counter_out),
    .Ctr_0             (Ctr_0),
    .comparator_out    (comparator_out),
    .comparator_out_cc (comparator_out_cc),
    .T1                (T1),
    .T2                (T2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic test_reset();
    Rst = 1'b0; Clk_en = 1'b0; Load_en = 1'b0; Load = '0; reg_cc = '0;
    step(2);
    Rst = 1'b1;
    step(1);
    n_tests++; if (counter_out !== 12'd0) begin n_fail++; $display("FAIL reset_counter: got %0d expected 0", counter_out); end
    n_tests++; if (op !== 12'hFFF) begin n_fail++; $display("FAIL reset_op: got %h expected fff", op); end
    n_tests++; if (Ctr_0 !== 1'b1) begin n_fail++; $display("FAIL reset_ctr0: got %b expected 1", Ctr_0); end
    n_tests++; if (comparator_out !== 1'b0) begin n_fail++; $display("FAIL reset_cmp_prd: got %b expected 0", comparator_out); end
    n_tests++; if (comparator_out_cc !== 1'b1) begin n_fail++; $display("FAIL reset_cmp_cc: got %b expected 1", comparator_out_cc); end
    n_tests++; if (T1 !== 1'b0 || T2 !== 1'b1) begin n_fail++; $display("FAIL reset_t1t2: got %b%b expected 01", T1, T2); end
    step(5);
    n_tests++; if (counter_out !== 12'd0 || op !== 12'hFFF) begin n_fail++; $display("FAIL reset_hold: got cnt %0d op %h expected 0 fff", counter_out, op); end
  endtask

  task automatic test_period_load();
    bit found;
    int zero_hits;
    int prd_hits;
    Load = 12'd540; Load_en = 1'b1; Clk_en = 1'b1;
    step(1);
    Load_en = 1'b0;
    n_tests++; if (op !== 12'hFFF || counter_out !== 12'd1) begin n_fail++; $display("FAIL load_no_early_op: got op %h cnt %0d expected fff 1", op, counter_out); end
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (counter_out == 12'd4095) begin
        n_tests++; if (op !== 12'hFFF || comparator_out !== 1'b1) begin n_fail++; $display("FAIL load_before_wrap: got op %h cmp %b expected fff 1", op, comparator_out); end
      end
      step(1);
      if (counter_out == 12'd0) begin found = 1'b1; break; end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL load_wrap_timeout: got no wrap expected wrap within 5000 clocks"); end
    n_tests++; if (op !== 12'd540) begin n_fail++; $display("FAIL load_op_after_wrap: got %0d expected 540", op); end
    zero_hits = 0; prd_hits = 0;
    for (int i = 0; i < 541; i++) begin
      if (Ctr_0) zero_hits++;
      if (comparator_out) prd_hits++;
      if (i == 540) begin
        n_tests++; if (counter_out !== 12'd540 || comparator_out !== 1'b1) begin n_fail++; $display("FAIL load_period_end: got cnt %0d cmp %b expected 540 1", counter_out, comparator_out); end
      end
      step(1);
    end
    n_tests++; if (zero_hits !== 1 || prd_hits !== 1) begin n_fail++; $display("FAIL load_pulse_count: got zero %0d prd %0d expected 1 1", zero_hits, prd_hits); end
    n_tests++; if (counter_out !== 12'd0) begin n_fail++; $display("FAIL load_rewrap: got %0d expected 0", counter_out); end
  endtask

  task automatic test_compare();
    int t1_err;
    int cc_err;
    reg_cc = 12'd270;
    step(541);
    t1_err = 0; cc_err = 0;
    for (int i = 0; i < 541; i++) begin
      if (counter_out !== 12'(i)) t1_err++;
      if (T1 !== (i < 270)) t1_err++;
      if (T2 !== ~T1) t1_err++;
      if (comparator_out_cc !== (i == 270)) cc_err++;
      step(1);
    end
    n_tests++; if (t1_err !== 0) begin n_fail++; $display("FAIL cmp_t1_shape: got %0d bad samples expected 0", t1_err); end
    n_tests++; if (cc_err !== 0) begin n_fail++; $display("FAIL cmp_cc_match: got %0d bad samples expected 0", cc_err); end
  endtask

  task automatic test_duty_extremes();
    int highs;
    int cc_hits;
    reg_cc = 12'd0;
    highs = 0;
    for (int i = 0; i < 541; i++) begin if (T1) highs++; step(1); end
    n_tests++; if (highs !== 270) begin n_fail++; $display("FAIL duty_old_cc: got %0d high expected 270", highs); end
    reg_cc = 12'd600;
    highs = 0;
    for (int i = 0; i < 541; i++) begin if (T1) highs++; step(1); end
    n_tests++; if (highs !== 0) begin n_fail++; $display("FAIL duty_zero: got %0d high expected 0", highs); end
    highs = 0; cc_hits = 0;
    for (int i = 0; i < 541; i++) begin
      if (T1) highs++;
      if (comparator_out_cc) cc_hits++;
      step(1);
    end
    n_tests++; if (highs !== 541) begin n_fail++; $display("FAIL duty_full: got %0d high expected 541", highs); end
    n_tests++; if (cc_hits !== 0) begin n_fail++; $display("FAIL duty_full_cc: got %0d hits expected 0", cc_hits); end
  endtask

  task automatic test_clk_en_hold();
    int bad;
    step(100);
    n_tests++; if (counter_out !== 12'd100) begin n_fail++; $display("FAIL hold_reach: got %0d expected 100", counter_out); end
    Clk_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (counter_out !== 12'd100 || op !== 12'd540) bad++;
      if (Ctr_0 !== 1'b0 || comparator_out !== 1'b0 || comparator_out_cc !== 1'b0) bad++;
      if (T1 !== 1'b1 || T2 !== 1'b0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL hold_paused: got %0d bad samples expected 0", bad); end
    Clk_en = 1'b1;
    step(1);
    n_tests++; if (counter_out !== 12'd101) begin n_fail++; $display("FAIL hold_resume: got %0d expected 101", counter_out); end
  endtask

  task automatic test_reset_mid();
    step(199);
    n_tests++; if (counter_out !== 12'd300) begin n_fail++; $display("FAIL rstmid_reach: got %0d expected 300", counter_out); end
    Rst = 1'b0; Load_en = 1'b1; Load = 12'd50;
    step(1);
    Rst = 1'b1; Load_en = 1'b0;
    n_tests++; if (counter_out !== 12'd0 || op !== 12'hFFF) begin n_fail++; $display("FAIL rstmid_state: got cnt %0d op %h expected 0 fff", counter_out, op); end
    n_tests++; if (T1 !== 1'b0 || comparator_out_cc !== 1'b1) begin n_fail++; $display("FAIL rstmid_cc: got t1 %b cc %b expected 0 1", T1, comparator_out_cc); end
    step(4096);
    n_tests++; if (counter_out !== 12'd0 || op !== 12'hFFF) begin n_fail++; $display("FAIL rstmid_shadow: got cnt %0d op %h expected 0 fff", counter_out, op); end
  endtask

  initial begin
    Rst = 1'b0; Clk_en = 1'b0; Load_en = 1'b0; Load = '0; reg_cc = '0;
    @(negedge Clock);
    test_reset();
    test_period_load();
    test_compare();
    test_duty_extremes();
    test_clk_en_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_head.md
Name: pwm_head

Overview:
- Top-level 12-bit PWM time-base block.
- Contains an up-counter that wraps at a programmable period, a shadowed period register and a shadowed compare register.
- Produces zero/period/compare match flags and a complementary PWM pair T1/T2.
- Sits between the register interface (Load/Load_en, reg_cc) and the output drivers.

Parameters:
- WIDTH, 12, width of counter, period and compare datapaths; all ports below are WIDTH bits where multi-bit.
- PRD_RESET, 12'hFFF, reset value of the shadow and active period registers.

Ports:
- Clock  input  1  single system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-low reset, sampled on the rising edge of Clock.
- Clk_en  input  1  count enable; counter and active-register updates occur only when high.
- Load_en  input  1  write strobe for the period shadow register.
- Load  input  12  period value written to the shadow register.
- reg_cc  input  12  compare value; sampled into the active compare register at each period boundary.
- op  output  12  active period register value.
- counter_out  output  12  current counter value.
- Ctr_0  output  1  high while counter_out == 0.
- comparator_out  output  1  high while counter_out == op (period match).
- comparator_out_cc  output  1  high while counter_out == active compare value.
- T1  output  1  PWM output.
- T2  output  1  complement of T1.

Behaviour:
- Reset is synchronous and active-low. A rising edge with Rst=0 sets:
  - counter = 0
  - shadow period = active period = PRD_RESET
  - active compare = 0
- Reset has priority over Load_en and Clk_en.
- Outputs immediately after reset:
  - counter_out = 0, op = 12'hFFF
  - Ctr_0 = 1, comparator_out = 0, comparator_out_cc = 1
  - T1 = 0, T2 = 1
- Shadow period: on a rising edge with Rst=1 and Load_en=1, shadow <= Load. This happens regardless of Clk_en and takes 1-cycle latency into the shadow. op does not change at that edge.
- Counter, on a rising edge with Rst=1 and Clk_en=1:
  - If counter == op: counter <= 0, op <= shadow period, active compare <= reg_cc (period boundary).
  - Otherwise: counter <= counter + 1.
- With Clk_en=0, counter, op and active compare all hold.
- Period: one PWM period is op+1 enabled clocks. With op = 0 the counter stays at 0, and every enabled edge is a boundary.
- Load_en on the same edge as a boundary: the boundary transfers the old shadow value; the new value reaches op at the next boundary.
- Ctr_0, comparator_out and comparator_out_cc are combinational decodes of registered state. They never depend combinationally on inputs.
- T1 = (counter_out < active compare), decoded from registered state; T2 = ~T1. This gives duty = cc/(op+1).
  - cc = 0 gives T1 constantly 0 (0% duty).
  - cc > op gives T1 constantly 1 (100% duty).
- Since op only changes at a wrap to 0, the counter can never exceed op, so no out-of-range state exists.
- Reset asserted mid-period: the counter returns to 0 on that edge and all pending shadow values are discarded.

Test Plan:
1. Rst=0 for 2 clocks, then Rst=1 with Clk_en=0 -> counter_out=0, op=12'hFFF, Ctr_0=1, comparator_out_cc=1, T1=0, T2=1; values hold while Clk_en=0.
2. Load=540 with a 1-cycle Load_en pulse after reset, Clk_en=1, reg_cc=0 -> op stays 0xFFF until counter wraps from 4095 to 0, then op=540. Afterwards the counter cycles 0..540: comparator_out pulses for 1 clock at 540, and Ctr_0 pulses for 1 clock at 0, every 541 clocks.
3. op=540, reg_cc=270 -> from the next boundary, T1=1 for counter 0..269 and 0 for 270..540. comparator_out_cc=1 exactly at counter=270. T2 is always ~T1.
4. reg_cc=0 and then reg_cc=600 with op=540 -> T1 constantly 0 after the first boundary; constantly 1 after the boundary following the change to 600.
5. Toggle Clk_en low for 10 clocks mid-period at counter=100 -> counter_out holds 100 and all flags hold; counting resumes at 101.
6. Assert Rst=0 while counter=300 with Load_en=1 and Load=50 on the same edge -> next cycle counter_out=0 and op=0xFFF; shadow=0xFFF (the load is ignored).
